shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
Parametrised multi-bit delay line with a runtime-programmable delay. It carries a valid tag alongside the data, has a stall enable and a flush-on-reconfigure rule, and tracks how many samples are in flight. It is used wherever datapath or control signals must be re-aligned by a configurable number of cycles, such as matching ALU, memory and decode latencies. It replaces fixed single-bit flop chains in new logic.

Parameters:
WIDTH, 8, data bits per sample (>=1)
MAX_DELAY, 4, number of physical stages; maximum programmable delay (>=1)
DEFAULT_DELAY, 4, delay_q value after reset (0..MAX_DELAY)
DW, $clog2(MAX_DELAY+1), width of the delay and count fields (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  shift enable; 0 = whole pipe holds
in_valid  input  1  input sample valid
in_data  input  WIDTH  input sample
cfg_load  input  1  load delay_cfg into delay_q and flush the pipe
delay_cfg  input  DW  requested delay in cycles
out_valid  output  1  output sample valid
out_data  output  WIDTH  output sample; 0 when out_valid=0
delay_q  output  DW  active delay
in_flight  output  DW  count of valid samples in stages 1..delay_q
busy  output  1  in_flight != 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits and data cleared to 0; delay_q=DEFAULT_DELAY; in_flight=0.
  - out_valid=0, out_data=0, busy=0 from the cycle after reset.
  - rst has priority over all other inputs, including mid-stream traffic.
- Storage: MAX_DELAY stages, each {valid, data}. When en=1, stage[1] <= {in_valid, in_data} and stage[k] <= stage[k-1]. Stage data may update even when its valid bit is 0.
- Output tap:
  - delay_q=0 is a combinational bypass: out_valid=in_valid&en, out_data=in_data or 0.
  - delay_q=N>0: out = stage[N]. Latency is exactly N enabled cycles; a sample taken with en=1 at edge t appears at stage N after N further enabled edges.
- en=0:
  - no stage updates; in_valid is dropped (not captured); out_valid/out_data hold their registered value.
  - In bypass mode with en=0, out_valid=0.
- cfg_load=1 (with rst=0), at the edge:
  - delay_q <= min(delay_cfg, MAX_DELAY); values above MAX_DELAY saturate.
  - All stage valid bits are cleared; the sample presented in that cycle is dropped; in_flight <= 0.
  - Applies regardless of en.
  - During the cfg_load cycle itself, outputs still reflect the old delay_q.
- in_flight:
  - Registered. Increments when en=1, delay_q>0 and in_valid=1. Decrements when en=1 and stage[delay_q].valid=1. Both together: unchanged.
  - Stages beyond delay_q never count.
  - Never exceeds delay_q; saturation is unreachable by construction, and the bench asserts it.
- busy is combinational from in_flight.
- Stages above delay_q still shift. They are ignored by the output and by in_flight.
- No backpressure: the pipe never refuses input while en=1.

Decomposition:
- Shared package: DW computation helper (clog2), a stage struct typedef {valid, data[WIDTH]}, and DEFAULT_DELAY range-check constants.
- One sub-module, shift_stage: a single {valid, data} register with clk, rst, en and clr (clears valid only), instantiated MAX_DELAY times in a generate loop.
- Top level holds the tap mux, delay_q register, in_flight counter and cfg/flush logic.

Test Plan:
- Reset and default latency: rst 2 cycles; WIDTH=8, MAX_DELAY=4, en=1; send 0x11,0x22,0x33 back-to-back -> out_valid=1 with 0x11,0x22,0x33 on cycles 4,5,6 after first input; in_flight peaks at 3; busy=0 afterward.
- Reconfigure: cfg_load with delay_cfg=2 while 3 samples are in flight -> those samples are never output; in_flight=0 next cycle; delay_q=2; next input 0xA5 appears exactly 2 cycles later.
- Bypass and saturation:
  - delay_cfg=0: in 0x5A with in_valid=1 -> out_data=0x5A, out_valid=1 same cycle.
  - delay_cfg=7 (MAX_DELAY=4) -> delay_q=4.
- Stall: delay 3; input 0x01; en=0 for 5 cycles after second edge -> output held; 0x01 emerges after 3 enabled edges (8 total); inputs presented during stall are dropped; in_flight unchanged during stall.
- Reset mid-stream: 4 valid samples in flight, rst=1 for one cycle -> out_valid=0, in_flight=0, delay_q=DEFAULT_DELAY next cycle; no stale sample ever emerges.
- Random soak: random in_valid/en/cfg_load against a reference queue model -> no loss or duplication except the defined flush drops; in_flight<=delay_q always.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// Shared helpers for the shift_pipe delay line: field-width derivation and
// delay range constants.
package shift_pipe_pkg;

   localparam int unsigned DefaultDelayMin = 0;

   function automatic int unsigned dw_of(input int unsigned max_delay);
      return $clog2(max_delay + 1);
   endfunction

   // Keeps an out-of-range DEFAULT_DELAY from producing an unreachable tap.
   function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_delay);
      if (d < DefaultDelayMin) return DefaultDelayMin;
      return (d > max_delay) ? max_delay : d;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One {valid, data} stage of the delay line; clr drops the valid bit only.
module shift_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (en) begin
         valid_d = d_valid;
         data_d  = d_data;
      end
      if (clr) valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign q_valid = valid_q;
   assign q_data  = data_q;

endmodule

// File: rtl/shift_pipe.sv
// Delay line with runtime-programmable tap, valid tagging, stall and
// flush-on-reconfigure; tracks how many valid samples sit inside the active delay.
module shift_pipe
   import shift_pipe_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned MAX_DELAY     = 4,
   parameter int unsigned DEFAULT_DELAY = 4,
   parameter int unsigned DW            = dw_of(MAX_DELAY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             cfg_load,
   input  logic [DW-1:0]    delay_cfg,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [DW-1:0]    delay_q,
   output logic [DW-1:0]    in_flight,
   output logic             busy
);

   localparam int unsigned NTap      = 2 ** DW;
   localparam logic [DW-1:0] MaxDelay = DW'(MAX_DELAY);
   localparam logic [DW-1:0] RstDelay = DW'(clamp_delay(DEFAULT_DELAY, MAX_DELAY));

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } stage_t;

   // tap[0] is the live input so delay 0 falls out as a bypass; taps past
   // MAX_DELAY pad the index space of delay_q and are never selected.
   stage_t [NTap-1:0] tap;
   stage_t            tap_sel;
   logic [DW-1:0]     delay_d;
   logic [DW-1:0]     in_flight_d, in_flight_q;
   logic              inc, dec, bypass;

   assign tap[0].valid = in_valid;
   assign tap[0].data  = in_data;

   for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
      shift_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .clr    (cfg_load),
         .d_valid(tap[k-1].valid),
         .d_data (tap[k-1].data),
         .q_valid(tap[k].valid),
         .q_data (tap[k].data)
      );
   end

   for (genvar k = MAX_DELAY + 1; k < NTap; k++) begin : g_pad
      assign tap[k] = '0;
   end

   always_comb begin
      bypass    = (delay_q == '0);
      tap_sel   = tap[delay_q];
      out_valid = tap_sel.valid & (en | ~bypass);
      out_data  = out_valid ? tap_sel.data : '0;
      busy      = (in_flight_q != '0);
   end

   always_comb begin
      delay_d = delay_q;
      if (cfg_load) delay_d = (delay_cfg > MaxDelay) ? MaxDelay : delay_cfg;
   end

   always_comb begin
      inc         = en & in_valid & ~bypass;
      dec         = en & tap_sel.valid & ~bypass;
      in_flight_d = in_flight_q;
      if (cfg_load)         in_flight_d = '0;
      else if (inc && !dec) in_flight_d = in_flight_q + 1'b1;
      else if (dec && !inc) in_flight_d = in_flight_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         delay_q     <= RstDelay;
         in_flight_q <= '0;
      end else begin
         delay_q     <= delay_d;
         in_flight_q <= in_flight_d;
      end
   end

   assign in_flight = in_flight_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and random checks of shift_pipe against an age-tracking sample model.
module tb_shift_pipe;

   localparam int unsigned WIDTH         = 8;
   localparam int unsigned MAX_DELAY     = 4;
   localparam int unsigned DEFAULT_DELAY = 4;
   localparam int unsigned DW            = $clog2(MAX_DELAY + 1);

   logic             clk, rst, en, in_valid, cfg_load, out_valid, busy;
   logic [WIDTH-1:0] in_data, out_data;
   logic [DW-1:0]    delay_cfg, delay_q, in_flight;

   int total = 0;
   int bad   = 0;

   shift_pipe #(
      .WIDTH        (WIDTH),
      .MAX_DELAY    (MAX_DELAY),
      .DEFAULT_DELAY(DEFAULT_DELAY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (in_valid),
      .in_data  (in_data),
      .cfg_load (cfg_load),
      .delay_cfg(delay_cfg),
      .out_valid(out_valid),
      .out_data (out_data),
      .delay_q  (delay_q),
      .in_flight(in_flight),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model: each accepted valid sample remembers how many enabled edges it has
   // aged; it is visible at the output when its age equals the active delay.
   typedef struct {
      logic [WIDTH-1:0] data;
      int unsigned      age;
   } item_t;

   item_t       mq[$];
   int unsigned m_delay = DEFAULT_DELAY;
   bit          m_live  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_delay = DEFAULT_DELAY;
         m_live  = 1'b1;
      end else if (m_live) begin
         if (cfg_load) begin
            mq.delete();
            m_delay = (int'(delay_cfg) > MAX_DELAY) ? MAX_DELAY : int'(delay_cfg);
         end else if (en) begin
            foreach (mq[i]) mq[i].age++;
            while (mq.size() > 0 && mq[0].age > m_delay) void'(mq.pop_front());
            if (in_valid && m_delay != 0) mq.push_back('{data: in_data, age: 1});
         end
      end
   end

   always @(negedge clk) begin
      logic             ev;
      logic [WIDTH-1:0] ed;
      int unsigned      cnt;
      if (m_live && !rst) begin
         ev  = 1'b0;
         ed  = '0;
         cnt = 0;
         if (m_delay == 0) begin
            ev = in_valid & en;
            ed = ev ? in_data : '0;
         end else begin
            foreach (mq[i]) begin
               if (mq[i].age <= m_delay) cnt++;
               if (mq[i].age == m_delay) begin
                  ev = 1'b1;
                  ed = mq[i].data;
               end
            end
         end
         chk("model out_valid", 32'(out_valid), 32'(ev));
         chk("model out_data", 32'(out_data), 32'(ed));
         chk("model delay_q", 32'(delay_q), 32'(m_delay));
         chk("model in_flight", 32'(in_flight), 32'(cnt));
         chk("model busy", 32'(busy), 32'(cnt != 0));
         chk("in_flight<=delay_q", 32'(in_flight <= delay_q), 32'd1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; cfg_load = 1'b0; delay_cfg = '0;
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("reset delay_q", 32'(delay_q), 32'd4);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", 32'(out_data), 32'd0);
      chk("reset in_flight", 32'(in_flight), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);

      // Default latency of 4
      en = 1'b1; in_valid = 1'b1;
      in_data = 8'h11; cyc();
      in_data = 8'h22; cyc();
      in_data = 8'h33; cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat in_flight peak", 32'(in_flight), 32'd3);
      chk("lat early out_valid", 32'(out_valid), 32'd0);
      cyc(); @(negedge clk);
      chk("lat out 11 valid", 32'(out_valid), 32'd1);
      chk("lat out 11", 32'(out_data), 32'h11);
      cyc(); @(negedge clk);
      chk("lat out 22", 32'(out_data), 32'h22);
      cyc(); @(negedge clk);
      chk("lat out 33", 32'(out_data), 32'h33);
      cyc(); @(negedge clk);
      chk("lat drained in_flight", 32'(in_flight), 32'd0);
      chk("lat drained busy", 32'(busy), 32'd0);
      chk("lat drained out_valid", 32'(out_valid), 32'd0);

      // Reconfigure with samples in flight
      in_valid = 1'b1;
      in_data = 8'h01; cyc();
      in_data = 8'h02; cyc();
      in_data = 8'h03; cyc();
      in_valid = 1'b0; cfg_load = 1'b1; delay_cfg = 3'd2;
      @(negedge clk);
      chk("cfg old delay_q", 32'(delay_q), 32'd4);
      chk("cfg pre in_flight", 32'(in_flight), 32'd3);
      cyc();
      cfg_load = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
      @(negedge clk);
      chk("cfg new delay_q", 32'(delay_q), 32'd2);
      chk("cfg flushed in_flight", 32'(in_flight), 32'd0);
      chk("cfg flushed out_valid", 32'(out_valid), 32'd0);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("cfg a5 not yet", 32'(out_valid), 32'd0);
      cyc(); @(negedge clk);
      chk("cfg a5 valid", 32'(out_valid), 32'd1);
      chk("cfg a5 data", 32'(out_data), 32'hA5);
      cyc(); @(negedge clk);
      chk("cfg no stale", 32'(out_valid), 32'd0);

      // Bypass and saturation
      cfg_load = 1'b1; delay_cfg = 3'd0;
      cyc();
      cfg_load = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
      @(negedge clk);
      chk("byp out_valid", 32'(out_valid), 32'd1);
      chk("byp out_data", 32'(out_data), 32'h5A);
      chk("byp in_flight", 32'(in_flight), 32'd0);
      en = 1'b0; #1;
      chk("byp stalled out_valid", 32'(out_valid), 32'd0);
      chk("byp stalled out_data", 32'(out_data), 32'd0);
      en = 1'b1; in_valid = 1'b0; cfg_load = 1'b1; delay_cfg = 3'd7;
      cyc();
      cfg_load = 1'b0;
      @(negedge clk);
      chk("sat delay_q", 32'(delay_q), 32'd4);

      // Stall with delay 3
      cfg_load = 1'b1; delay_cfg = 3'd3;
      cyc();
      cfg_load = 1'b0; in_valid = 1'b1; in_data = 8'h01;
      cyc();
      in_valid = 1'b0;
      cyc();
      en = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall in_flight", 32'(in_flight), 32'd1);
         chk("stall out_valid", 32'(out_valid), 32'd0);
         cyc();
      end
      en = 1'b1; in_valid = 1'b0;
      cyc(); @(negedge clk);
      chk("stall emerge valid", 32'(out_valid), 32'd1);
      chk("stall emerge data", 32'(out_data), 32'h01);
      cyc(); @(negedge clk);
      chk("stall dropped out_valid", 32'(out_valid), 32'd0);
      chk("stall dropped in_flight", 32'(in_flight), 32'd0);

      // Reset mid-stream with delay 4
      cfg_load = 1'b1; delay_cfg = 3'd4;
      cyc();
      cfg_load = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'hC0 + 8'(i);
         cyc();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid in_flight full", 32'(in_flight), 32'd4);
      chk("mid busy", 32'(busy), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("mid rst out_valid", 32'(out_valid), 32'd0);
      chk("mid rst in_flight", 32'(in_flight), 32'd0);
      chk("mid rst delay_q", 32'(delay_q), 32'(DEFAULT_DELAY));
      for (int i = 0; i < 6; i++) begin
         cyc(); @(negedge clk);
         chk("mid no stale", 32'(out_valid), 32'd0);
      end

      // Random soak, checked by the model compare process
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(0, 3) != 0);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         cfg_load  = ($urandom_range(0, 31) == 0);
         delay_cfg = 3'($urandom_range(0, 7));
         rst       = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
      cyc();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
